// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one two-digit 7-segment display among NUM_REQ byte sources,
// with a minimum hold time per grant and a registered byte/valid output.
module seg_display_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 25000000
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   input  logic [NUM_REQ-1:0]   i_Req,
   input  logic [8*NUM_REQ-1:0] i_Data,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic [2:0]           o_Grant_Id,
   output logic [7:0]           o_Display_Byte,
   output logic                 o_Display_Valid
);

   localparam int CW = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, OWNED} state_t;

   state_t            state;
   logic [2:0]        ptr;
   logic [CW-1:0]     cnt;

   logic [2*NUM_REQ-1:0] req_rot;
   logic                 sel_found;
   int                   sel_off;
   logic [3:0]           sel_sum;
   logic [2:0]           sel_id;
   logic [2:0]           ptr_nxt;
   logic                 own_req;
   logic                 others_req;
   logic                 hold_done;
   logic [7:0]           cur_byte;

   // Rotate requests so bit 0 is the pointer position; first set bit wins.
   always_comb begin
      req_rot   = {i_Req, i_Req} >> ptr;
      sel_found = 1'b0;
      sel_off   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!sel_found && req_rot[i]) begin
            sel_found = 1'b1;
            sel_off   = i;
         end
      end
      sel_sum = {1'b0, ptr} + 4'(sel_off);
      if (sel_sum >= 4'(NUM_REQ)) sel_sum = sel_sum - 4'(NUM_REQ);
      sel_id  = sel_sum[2:0];
      ptr_nxt = (sel_id == 3'(NUM_REQ - 1)) ? 3'd0 : sel_id + 3'd1;
   end

   always_comb begin
      own_req    = |(i_Req & o_Grant);
      others_req = |(i_Req & ~o_Grant);
      hold_done  = (state == OWNED) || (state == HOLD && cnt == '0);
      cur_byte   = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (o_Grant_Id == 3'(i)) cur_byte = i_Data[8*i +: 8];
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state           <= IDLE;
         ptr             <= 3'd0;
         cnt             <= '0;
         o_Grant         <= '0;
         o_Grant_Id      <= 3'd0;
         o_Display_Byte  <= 8'h00;
         o_Display_Valid <= 1'b0;
      end else begin
         if (o_Grant != '0) o_Display_Byte <= cur_byte;
         // Valid rises one edge after a grant and stays up across handovers.
         o_Display_Valid <= (state != IDLE);
         if (state == IDLE || !own_req || (hold_done && others_req)) begin
            if (sel_found) begin
               o_Grant    <= NUM_REQ'(1) << sel_id;
               o_Grant_Id <= sel_id;
               ptr        <= ptr_nxt;
               cnt        <= HOLD_LOAD;
               state      <= (HOLD_CYCLES == 1) ? OWNED : HOLD;
            end else begin
               o_Grant         <= '0;
               o_Grant_Id      <= 3'd0;
               o_Display_Valid <= 1'b0;
               state           <= IDLE;
            end
         end else if (state == HOLD) begin
            if (cnt == '0) state <= OWNED;
            else           cnt   <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized plus directed bench for seg_display_arbiter, checked against a
// behavioural owner/age reference model.
module tb_seg_display_arbiter;
   localparam int N = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  grant;
   logic [2:0]  gid;
   logic [7:0]  dbyte;
   logic        dvalid;

   int total = 0;
   int bad   = 0;

   int         m_owner, m_ptr, m_age;
   logic [7:0] m_byte;
   logic       m_valid;

   seg_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Req(req), .i_Data(data),
      .o_Grant(grant), .o_Grant_Id(gid), .o_Display_Byte(dbyte), .o_Display_Valid(dvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_age = 0; m_byte = 8'h00; m_valid = 1'b0;
   endtask

   task automatic model_grant(input int k);
      m_owner = k; m_ptr = (k + 1) % N; m_age = 1;
   endtask

   // One clock edge of the spec-level behaviour: owner, cycles held, rr pointer.
   task automatic model_edge();
      int prev, k;
      logic [3:0] others;
      prev = m_owner;
      if (prev >= 0) m_byte = 8'(data >> (8 * prev));
      if (m_owner < 0) begin
         k = pick(req, m_ptr);
         if (k >= 0) model_grant(k);
      end else begin
         others = req & ~(4'(1) << m_owner);
         if (!req[m_owner] || (m_age >= H && others != 0)) begin
            k = pick(req, m_ptr);
            if (k >= 0) model_grant(k);
            else m_owner = -1;
         end else begin
            m_age++;
         end
      end
      m_valid = (prev >= 0) && (m_owner >= 0);
   endtask

   task automatic check_all();
      chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("grant_id", 32'(gid), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("valid", 32'(dvalid), 32'(m_valid));
      chk("byte", 32'(dbyte), 32'(m_byte));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      #1 check_all();
   endtask

   // Called just after an edge; pulses reset away from any clock edge.
   task automatic arst_pulse();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_valid", 32'(dvalid), 32'd0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; data = '0;
      model_reset();
      // Reset held with random inputs
      repeat (5) begin
         req = 4'($urandom); data = $urandom;
         step();
      end
      chk("rst_byte", 32'(dbyte), 32'd0);
      req = '0; rst_n = 1'b1;
      repeat (20) step();

      // Single requester, data tracking
      req = 4'b0100; data[23:16] = 8'h5A;
      step();
      chk("single_grant", 32'(grant), 32'b0100);
      chk("single_id", 32'(gid), 32'd2);
      step();
      chk("single_byte", 32'(dbyte), 32'h5A);
      repeat (50) step();
      data[23:16] = 8'hC3;
      step();
      chk("single_follow", 32'(dbyte), 32'hC3);
      req = '0;
      step();

      // Rotation with all requesting from pointer 0
      arst_pulse();
      req = 4'b1111; data = $urandom;
      repeat (22) begin
         step();
         data = $urandom;
      end

      // No preemption during hold
      arst_pulse();
      req = 4'b0001;
      step();
      req = 4'b0011;
      repeat (8) step();

      // Early release then new requester
      arst_pulse();
      req = 4'b0100;
      step();
      step();
      req = 4'b0000;
      step();
      chk("release_valid", 32'(dvalid), 32'd0);
      req = 4'b0001;
      step();
      chk("release_regrant", 32'(grant), 32'b0001);

      // Async reset while source 3 owns, then pointer restarts at 0
      req = 4'b1000; data[31:24] = 8'hFF;
      repeat (10) step();
      arst_pulse();
      req = 4'b1001;
      step();
      chk("arst_first", 32'(grant), 32'b0001);
      repeat (3) step();

      // Random requests and data, held for random spans
      repeat (300) begin
         int len;
         req = 4'($urandom);
         len = $urandom_range(1, 8);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 2) == 0) data = $urandom;
            step();
         end
         if ($urandom_range(0, 40) == 0) arst_pulse();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
